// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I subset core.
// Shared ALU and unified memory port, memory watchdog, retire counter.
module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_src,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             err,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_ALU,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WD_W-1:0]  r_wd;
  logic [WD_W-1:0]  w_wd_inc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_mem_st;
  logic             w_tmo;
  logic             w_retire;
  logic [6:0]       w_op;
  logic [2:0]       w_f3;
  logic             w_is_r;
  logic             w_is_addi;
  logic             w_is_ls;
  logic             w_is_br;
  logic             w_is_jal;

  assign w_op      = instr[6:0];
  assign w_f3      = instr[14:12];
  assign w_is_r    = (w_op == 7'b0110011)
                  && (w_f3 == 3'b000);
  assign w_is_addi = (w_op == 7'b0010011)
                  && (w_f3 == 3'b000);
  assign w_is_ls   = ((w_op == 7'b0000011)
                  || (w_op == 7'b0100011))
                  && (w_f3 == 3'b010);
  assign w_is_br   = (w_op == 7'b1100011)
                  && (w_f3[2:1] == 2'b00);
  assign w_is_jal  = (w_op == 7'b1101111);

  assign w_mem_st = (r_state == S_FETCH)
                 || (r_state == S_MEM_RD)
                 || (r_state == S_MEM_WR);

  // Wait cycle that would bring the count to the limit trips the watchdog.
  assign w_wd_inc = r_wd + 1'b1;
  assign w_tmo    = (TIMEOUT_CYCLES != 0) && !mem_ready
                 && (w_wd_inc == WD_W'(TIMEOUT_CYCLES));

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = 3'b000;
    imm_src    = 2'b00;
    result_src = 2'b00;
    err        = 1'b0;
    w_retire   = 1'b0;
    w_next     = r_state;
    if (!rst) begin
      unique case (r_state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          if (mem_ready) begin
            ir_we  = 1'b1;
            pc_we  = 1'b1;
            w_next = S_DECODE;
          end else if (w_tmo) begin
            w_next = S_ERROR;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = 2'b10;
          unique case (1'b1)
            w_is_r:    w_next = S_EXEC_R;
            w_is_addi: w_next = S_EXEC_I;
            w_is_ls:   w_next = S_MEM_ADDR;
            w_is_br:   w_next = S_BRANCH;
            w_is_jal:  w_next = S_JUMP;
            default:   w_next = S_ERROR;
          endcase
        end
        S_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_ctrl  = {2'b00, instr[30]};
          w_next    = S_WB_ALU;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          w_next    = S_WB_ALU;
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = {1'b0, instr[5]};
          w_next    = instr[5] ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          addr_src = 1'b1;
          if (mem_ready)  w_next = S_WB_MEM;
          else if (w_tmo) w_next = S_ERROR;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_src = 1'b1;
          if (mem_ready) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else if (w_tmo) begin
            w_next = S_ERROR;
          end
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_ctrl  = 3'b001;
          pc_we     = instr[12] ? ~zero : zero;
          w_retire  = 1'b1;
          w_next    = S_FETCH;
        end
        S_JUMP: begin
          pc_we     = 1'b1;
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          w_next    = S_WB_ALU;
        end
        S_ERROR: begin
          err = 1'b1;
        end
        default: w_next = S_ERROR;
      endcase
    end
    instr_done = w_retire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wd    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wd <= '0;
      else if (w_mem_st && !mem_ready)
        r_wd <= w_wd_inc;
      if (w_retire)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign instr_count = r_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle
// transaction model plus directed literal checks.
module tb_multicycle_ctrl;
  localparam int TO = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_src, ir_we, pc_we;
  logic        reg_write, err, instr_done;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]  alu_ctrl;
  logic [31:0] instr_count;
  logic [18:0] w_dut;

  typedef struct {
    logic [31:0] ins;
    logic        rdy;
    logic        z;
    logic [18:0] o;
    logic [31:0] cnt;
  } cyc_t;

  cyc_t        q[$];
  cyc_t        cur;
  bit          chk_on = 1'b0;
  int          cur_idx = 0;
  int          done_idx = 0;
  int          wbm_idx = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] m_cnt = 32'd0;
  logic [31:0] m_ins = 32'd0;
  logic        m_z = 1'b0;

  multicycle_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instr(instr),
    .zero(zero),
    .mem_ready(mem_ready),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .addr_src(addr_src),
    .ir_we(ir_we),
    .pc_we(pc_we),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl),
    .imm_src(imm_src),
    .result_src(result_src),
    .err(err),
    .instr_done(instr_done),
    .instr_count(instr_count)
  );

  assign w_dut = {mem_req, mem_we, addr_src, ir_we,
                  pc_we, reg_write, alu_src_a, alu_src_b,
                  alu_ctrl, imm_src, result_src, err,
                  instr_done};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_on) begin
      n_chk++;
      if (w_dut !== cur.o || instr_count !== cur.cnt) begin
        n_fail++;
        $display("FAIL cyc%0d ins=%h: got %b cnt=%0d, expected %b cnt=%0d",
                 cur_idx, cur.ins, w_dut, instr_count, cur.o, cur.cnt);
      end
      if (instr_done) done_idx = cur_idx;
      if (reg_write && result_src == 2'b01 && wbm_idx == 0)
        wbm_idx = cur_idx;
    end
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [18:0] mk(
    input logic req, input logic we, input logic asrc,
    input logic irwe, input logic pcwe, input logic rw,
    input logic [1:0] sa, input logic [1:0] sb,
    input logic [2:0] alu, input logic [1:0] imm,
    input logic [1:0] res, input logic er, input logic dn);
    return {req, we, asrc, irwe, pcwe, rw, sa, sb,
            alu, imm, res, er, dn};
  endfunction

  task automatic add(input logic rdy, input logic [18:0] o);
    cyc_t c;
    c.ins = m_ins;
    c.rdy = rdy;
    c.z   = m_z;
    c.o   = o;
    c.cnt = m_cnt;
    q.push_back(c);
  endtask

  task automatic retire(input logic rdy, input logic [18:0] o);
    add(rdy, o);
    m_cnt++;
  endtask

  task automatic add_err(input int n);
    repeat (n)
      add(L, mk(L,L,L,L,L,L,2'd0,2'd0,3'd0,2'd0,2'd0,H,L));
  endtask

  task automatic mem_wait(input logic [18:0] o, input int waits,
                          output bit to);
    to = 1'b0;
    for (int i = 0; i < waits && !to; i++) begin
      add(L, o);
      if (i + 1 == TO) to = 1'b1;
    end
  endtask

  // Expected cycle-by-cycle outputs for one instruction,
  // with fw / mw wait cycles before mem_ready in fetch / data access.
  task automatic plan(input logic [31:0] ins, input logic z,
                      input int fw, input int mw);
    bit          to;
    int          k;
    logic        tk;
    logic [2:0]  f3;
    logic [18:0] wba, mr, mw_o;
    f3    = ins[14:12];
    m_ins = ins;
    m_z   = z;
    case (ins[6:0])
      7'b0110011: k = (f3 == 3'd0) ? 0 : 6;
      7'b0010011: k = (f3 == 3'd0) ? 1 : 6;
      7'b0000011: k = (f3 == 3'd2) ? 2 : 6;
      7'b0100011: k = (f3 == 3'd2) ? 3 : 6;
      7'b1100011: k = (f3[2:1] == 2'd0) ? 4 : 6;
      7'b1101111: k = 5;
      default:    k = 6;
    endcase
    wba  = mk(L,L,L,L,L,H,2'd0,2'd0,3'd0,2'd0,2'd0,L,H);
    mr   = mk(H,L,H,L,L,L,2'd0,2'd0,3'd0,2'd0,2'd0,L,L);
    mw_o = mk(H,H,H,L,L,L,2'd0,2'd0,3'd0,2'd0,2'd0,L,L);
    mem_wait(mk(H,L,L,L,L,L,2'd0,2'd2,3'd0,2'd0,2'd2,L,L), fw, to);
    if (to) begin
      add_err(3);
      return;
    end
    add(H, mk(H,L,L,H,H,L,2'd0,2'd2,3'd0,2'd0,2'd2,L,L));
    add(L, mk(L,L,L,L,L,L,2'd1,2'd1,3'd0,2'd2,2'd0,L,L));
    case (k)
      0: begin
        add(L, mk(L,L,L,L,L,L,2'd2,2'd0,
                  ins[30] ? 3'd1 : 3'd0,2'd0,2'd0,L,L));
        retire(L, wba);
      end
      1: begin
        add(L, mk(L,L,L,L,L,L,2'd2,2'd1,3'd0,2'd0,2'd0,L,L));
        retire(L, wba);
      end
      2: begin
        add(L, mk(L,L,L,L,L,L,2'd2,2'd1,3'd0,2'd0,2'd0,L,L));
        mem_wait(mr, mw, to);
        if (to) begin
          add_err(3);
          return;
        end
        add(H, mr);
        retire(L, mk(L,L,L,L,L,H,2'd0,2'd0,3'd0,2'd0,2'd1,L,H));
      end
      3: begin
        add(L, mk(L,L,L,L,L,L,2'd2,2'd1,3'd0,2'd1,2'd0,L,L));
        mem_wait(mw_o, mw, to);
        if (to) begin
          add_err(3);
          return;
        end
        retire(H, mk(H,H,H,L,L,L,2'd0,2'd0,3'd0,2'd0,2'd0,L,H));
      end
      4: begin
        tk = f3[0] ? ~z : z;
        retire(L, mk(L,L,L,L,tk,L,2'd2,2'd0,3'd1,2'd0,2'd0,L,H));
      end
      5: begin
        add(L, mk(L,L,L,L,H,L,2'd1,2'd2,3'd0,2'd0,2'd0,L,L));
        retire(L, wba);
      end
      default: add_err(3);
    endcase
  endtask

  task automatic run_n(input int n);
    int idx = 0;
    done_idx = 0;
    wbm_idx  = 0;
    while (q.size() > 0 && idx < n) begin
      cur = q.pop_front();
      idx++;
      cur_idx   = idx;
      instr     = cur.ins;
      mem_ready = cur.rdy;
      zero      = cur.z;
      chk_on    = 1'b1;
      @(posedge clk);
      #1;
    end
    chk_on = 1'b0;
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_outputs", 32'(w_dut), 32'd0);
    check("rst_count", instr_count, 32'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cnt = 32'd0;
  endtask

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] BNE  = 32'h00209463;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h402081B3;
  localparam logic [31:0] LW   = 32'h0000A283;
  localparam logic [31:0] SW   = 32'h0020A223;
  localparam logic [31:0] JAL  = 32'h008000EF;
  localparam logic [31:0] BAD  = 32'h0000007F;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 32'(w_dut), 32'd0);
    check("rst_count", instr_count, 32'd0);
    rst = 1'b0;

    plan(ADDI, L, 0, 0);
    run_n(1000);
    check("addi_done_cycle", 32'(done_idx), 32'd4);
    check("addi_count", instr_count, 32'd1);

    plan(BNE, H, 0, 0); run_n(1000);
    plan(BNE, L, 0, 0); run_n(1000);
    plan(BEQ, H, 0, 0); run_n(1000);
    plan(BEQ, L, 0, 0); run_n(1000);
    plan(ADD, L, 0, 0); run_n(1000);
    plan(SUB, L, 0, 0); run_n(1000);

    plan(LW, L, 3, 2);
    run_n(1000);
    check("lw_wbmem_cycle", 32'(wbm_idx), 32'd10);
    check("lw_done_cycle", 32'(done_idx), 32'd10);

    plan(JAL, L, 0, 0); run_n(1000);
    plan(SW, L, 3, 3); run_n(1000);
    check("retired_count", instr_count, 32'd10);

    plan(SW, L, 0, 9);
    run_n(1000);
    check("sw_timeout_err", 32'(err), 32'd1);
    check("sw_timeout_req", 32'(mem_req), 32'd0);
    check("sw_timeout_count", instr_count, 32'd10);

    do_reset();
    plan(ADDI, L, 0, 0); run_n(1000);
    plan(BAD, L, 0, 0); run_n(1000);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_count", instr_count, 32'd1);

    do_reset();
    plan(ADDI, L, 5, 0);
    run_n(1000);
    check("fetch_timeout_err", 32'(err), 32'd1);

    do_reset();
    plan(ADDI, L, 0, 0); run_n(1000);
    plan(SW, L, 0, 3);
    run_n(5);
    mem_ready = 1'b0;
    #2;
    check("midwr_we_before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("midwr_we_async", 32'(mem_we), 32'd0);
    check("midwr_req_async", 32'(mem_req), 32'd0);
    check("midwr_count", instr_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_fetch_req", 32'(mem_req), 32'd1);
    check("post_rst_fetch_srcb", 32'(alu_src_b), 32'd2);
    check("post_rst_we", 32'(mem_we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
